// File: rtl/int_regfile_sb.sv
// int_regfile_sb: integer register file with a per-entry pending (scoreboard) bit.
// Two combinational read ports, one writeback port, and one allocation port.
// Entry 0 is hardwired to zero and is never pending.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback
// data to matching read ports and to show those ports as not busy.
module int_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              alloc_en_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic              rd_busy_a_o,
  output logic              rd_busy_b_o,
  output logic [ADDR_W:0]   busy_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_d;
  logic              wr_vld;
  logic              alloc_vld;

  assign wr_vld    = wr_en_i && (wr_addr_i != '0);
  assign alloc_vld = alloc_en_i && (alloc_addr_i != '0);

  // Next pending vector: writeback clears, allocation sets afterwards so it wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_vld)    pend_d[wr_addr_i]    = 1'b0;
    if (alloc_vld) pend_d[alloc_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Population count of the next pending vector; bit 0 is always clear, so the
  // count tops out at DEPTH-1 and fits in ADDR_W+1 bits without wrapping.
  always_comb begin
    busy_cnt_d = '0;
    for (int i = 1; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end
  end

  // State update; reset overrides any same-cycle write or allocation.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (wr_vld) mem_q[wr_addr_i] <= wr_data_i;
      pend_q     <= pend_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt_o = busy_cnt_q;

  // mem_q[0] is only ever reset, so index 0 reads zero without a special case.
`ifdef REGFILE_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  assign fwd_a = wr_vld && (wr_addr_i == rd_addr_a_i);
  assign fwd_b = wr_vld && (wr_addr_i == rd_addr_b_i);

  assign rd_data_a_o = fwd_a ? wr_data_i : mem_q[rd_addr_a_i];
  assign rd_data_b_o = fwd_b ? wr_data_i : mem_q[rd_addr_b_i];
  assign rd_busy_a_o = fwd_a ? 1'b0 : pend_q[rd_addr_a_i];
  assign rd_busy_b_o = fwd_b ? 1'b0 : pend_q[rd_addr_b_i];
`else
  assign rd_data_a_o = mem_q[rd_addr_a_i];
  assign rd_data_b_o = mem_q[rd_addr_b_i];
  assign rd_busy_a_o = pend_q[rd_addr_a_i];
  assign rd_busy_b_o = pend_q[rd_addr_b_i];
`endif

endmodule

// File: tb/tb_int_regfile_sb.sv
// Scoreboard bench for int_regfile_sb: stimulus pushes expected read-port values
// for the current cycle; a negedge monitor pops and compares.
module tb_int_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rsn;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic [ADDR_W:0]   busy_cnt;

  typedef struct packed {
    logic [DATA_W-1:0] da;
    logic              ba;
    logic [DATA_W-1:0] db;
    logic              bb;
    logic [ADDR_W:0]   cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [DATA_W-1:0] shadow [32];

  int_regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rsn_i       (rsn),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .alloc_en_i  (alloc_en),
    .alloc_addr_i(alloc_addr),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .rd_data_a_o (rd_data_a),
    .rd_data_b_o (rd_data_b),
    .rd_busy_a_o (rd_busy_a),
    .rd_busy_b_o (rd_busy_b),
    .busy_cnt_o  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: compares the oldest expectation against the outputs at mid-cycle.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (rd_data_a !== e.da || rd_busy_a !== e.ba || rd_data_b !== e.db ||
          rd_busy_b !== e.bb || busy_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: got a=%h/%b b=%h/%b cnt=%0d, want a=%h/%b b=%h/%b cnt=%0d",
                 nm, rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, busy_cnt,
                 e.da, e.ba, e.db, e.bb, e.cnt);
      end
    end
  end

  task automatic drive(input logic r, input logic we, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic ae,
                       input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ra,
                       input logic [ADDR_W-1:0] rb);
    rsn = r; wr_en = we; wr_addr = wa; wr_data = wd;
    alloc_en = ae; alloc_addr = aa; rd_addr_a = ra; rd_addr_b = rb;
  endtask

  task automatic expect_now(input string nm, input logic [DATA_W-1:0] da, input logic ba,
                            input logic [DATA_W-1:0] db, input logic bb,
                            input logic [ADDR_W:0] cnt);
    exp_t e;
    e.da = da; e.ba = ba; e.db = db; e.bb = bb; e.cnt = cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    tick();
    tick();

    // Reset state across every index on both ports.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'(i), 5'(31 - i));
      expect_now($sformatf("reset_read_%0d", i), '0, 1'b0, '0, 1'b0, '0);
      tick();
    end

    // Entry 0 ignores writes and allocations.
    drive(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0, 5'd0);
    expect_now("zero_write_same", '0, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0);
    expect_now("zero_write_next", '0, 1'b0, '0, 1'b0, '0);
    tick();

    // Allocate 5, then write it back.
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 5'd5, 5'd5);
    expect_now("alloc5_same", '0, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd5);
    expect_now("alloc5_next", '0, 1'b1, '0, 1'b1, 6'd1);
    tick();
    drive(1'b0, 1'b1, 5'd5, 32'h12345678, 1'b0, '0, 5'd5, 5'd5);
    expect_now("wr5_same", BYP ? 32'h12345678 : 32'h0, BYP ? 1'b0 : 1'b1,
               BYP ? 32'h12345678 : 32'h0, BYP ? 1'b0 : 1'b1, 6'd1);
    shadow[5] = 32'h12345678;
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd5);
    expect_now("wr5_next", 32'h12345678, 1'b0, 32'h12345678, 1'b0, '0);
    tick();

    // Same-cycle alloc and write to 7: data lands, pending bit stays set.
    drive(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 5'd7, 5'd5);
    expect_now("allocwr7_same", BYP ? 32'hA5A5A5A5 : 32'h0, 1'b0, 32'h12345678, 1'b0, '0);
    shadow[7] = 32'hA5A5A5A5;
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd5);
    expect_now("allocwr7_next", 32'hA5A5A5A5, 1'b1, 32'h12345678, 1'b0, 6'd1);
    tick();

    // Write to non-pending 9 with a same-cycle read.
    drive(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, '0, 5'd9, 5'd7);
    expect_now("wr9_same", BYP ? 32'hCAFEF00D : 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1, 6'd1);
    shadow[9] = 32'hCAFEF00D;
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd7);
    expect_now("wr9_next", 32'hCAFEF00D, 1'b0, 32'hA5A5A5A5, 1'b1, 6'd1);
    tick();

    // Re-allocating a pending index keeps the count at one.
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd9);
    expect_now("realloc7_same", 32'hA5A5A5A5, 1'b1, 32'hCAFEF00D, 1'b0, 6'd1);
    tick();
    drive(1'b1 & 1'b0, 1'b1, 5'd7, 32'h00000011, 1'b0, '0, 5'd7, 5'd9);
    expect_now("realloc7_next", BYP ? 32'h00000011 : 32'hA5A5A5A5, BYP ? 1'b0 : 1'b1,
               32'hCAFEF00D, 1'b0, 6'd1);
    shadow[7] = 32'h00000011;
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd0);
    expect_now("clear7_next", 32'h00000011, 1'b0, '0, 1'b0, '0);
    tick();

    // Fill every pending bit, one per cycle.
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 5'(i), 5'(i), 5'd0);
      expect_now($sformatf("fill_%0d", i), shadow[i], 1'b0, '0, 1'b0, 6'(i - 1));
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd31);
    expect_now("fill_full", '0, 1'b1, '0, 1'b1, 6'd31);
    tick();

    // Reset with a concurrent write and allocation; reset wins.
    drive(1'b1, 1'b1, 5'd3, 32'h33333333, 1'b1, 5'd2, 5'd5, 5'd4);
    expect_now("reset_cycle", 32'h12345678, 1'b1, '0, 1'b1, 6'd31);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd5);
    expect_now("after_reset", '0, 1'b0, '0, 1'b0, '0);
    tick();

    // Normal allocation resumes after reset.
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd4, 5'd4, 5'd2);
    expect_now("post_alloc_same", '0, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd4, 5'd2);
    expect_now("post_alloc_next", '0, 1'b1, '0, 1'b0, 6'd1);
    tick();

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
